// File: rtl/nios2_onchip_memory_dp.sv
// True dual-port Avalon-MM on-chip RAM: byte-lane writes, explicit cross-port write
// bypass on reads, and a stallable READ_LATENCY-deep read-return pipeline per port.
module nios2_onchip_memory_dp #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 15,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "nios2_onchip_memory_dp.hex"
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clken,
   input  logic                reset_req,
   input  logic [ADDR_W-1:0]   a_address,
   input  logic                a_chipselect,
   input  logic                a_read,
   input  logic                a_write,
   input  logic [DATA_W/8-1:0] a_byteenable,
   input  logic [DATA_W-1:0]   a_writedata,
   output logic [DATA_W-1:0]   a_readdata,
   output logic                a_readdatavalid,
   input  logic [ADDR_W-1:0]   b_address,
   input  logic                b_chipselect,
   input  logic                b_read,
   input  logic                b_write,
   input  logic [DATA_W/8-1:0] b_byteenable,
   input  logic [DATA_W-1:0]   b_writedata,
   output logic [DATA_W-1:0]   b_readdata,
   output logic                b_readdatavalid
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   // The array image comes from INIT_FILE through the device configuration; reset never touches it.
   if ($bits(INIT_FILE) == 0) begin : g_no_init_image
   end

   logic [DATA_W-1:0]       mem [DEPTH];
   logic                    en;
   logic [ADDR_W-1:0]       addr    [2];
   logic [NB-1:0]           be      [2];
   logic [DATA_W-1:0]       wdata   [2];
   logic [DATA_W-1:0]       rd_word [2];
   logic [1:0]              wr;
   logic [1:0]              rd_acc;
   logic [READ_LATENCY-1:0] vld_q [2];
   logic [READ_LATENCY-1:0] vld_d [2];
   logic [DATA_W-1:0]       dat_q [2][READ_LATENCY];
   logic [DATA_W-1:0]       dat_d [2][READ_LATENCY];

   assign en = clken & ~reset_req;

   assign addr[0]  = a_address;
   assign addr[1]  = b_address;
   assign be[0]    = a_byteenable;
   assign be[1]    = b_byteenable;
   assign wdata[0] = a_writedata;
   assign wdata[1] = b_writedata;

   assign wr[0]     = a_chipselect & a_write & en;
   assign wr[1]     = b_chipselect & b_write & en;
   assign rd_acc[0] = a_chipselect & a_read & ~a_write & en;
   assign rd_acc[1] = b_chipselect & b_read & ~b_write & en;

   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     lane_en);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++) begin
         if (lane_en[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   // Reads see this cycle's writes: b lanes first, then a lanes so a wins on overlap.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_word[p] = mem[addr[p]];
         if (wr[1] && (addr[1] == addr[p])) rd_word[p] = merge_lanes(rd_word[p], wdata[1], be[1]);
         if (wr[0] && (addr[0] == addr[p])) rd_word[p] = merge_lanes(rd_word[p], wdata[0], be[0]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wr[1] && be[1][i]) mem[addr[1]][8*i +: 8] <= wdata[1][8*i +: 8];
         if (wr[0] && be[0][i]) mem[addr[0]][8*i +: 8] <= wdata[0][8*i +: 8];
      end
   end

   // Data stages only load behind a valid entry so the last stage holds the last returned word.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (en) begin
         for (int p = 0; p < 2; p++) begin
            vld_d[p][0] = rd_acc[p];
            if (rd_acc[p]) dat_d[p][0] = rd_word[p];
            for (int k = 1; k < READ_LATENCY; k++) begin
               vld_d[p][k] = vld_q[p][k-1];
               if (vld_q[p][k-1]) dat_d[p][k] = dat_q[p][k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < 2; p++) begin
            vld_q[p] <= '0;
            for (int k = 0; k < READ_LATENCY; k++) dat_q[p][k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign a_readdatavalid = vld_q[0][READ_LATENCY-1] & en;
   assign b_readdatavalid = vld_q[1][READ_LATENCY-1] & en;
   assign a_readdata      = dat_q[0][READ_LATENCY-1];
   assign b_readdata      = dat_q[1][READ_LATENCY-1];

endmodule

// File: tb/tb_nios2_onchip_memory_dp.sv
// Drives one stimulus stream into three RAM instances (READ_LATENCY 1, 2, 3) and checks
// every port every cycle against a word-level memory model with per-read return schedules.
module tb_nios2_onchip_memory_dp;
   typedef struct {
      int          tag;
      logic [31:0] data;
   } rsp_t;

   logic        clk, reset_n, clken, reset_req;
   logic [14:0] a_addr, b_addr;
   logic        a_cs, a_rd, a_wr, b_cs, b_rd, b_wr;
   logic [3:0]  a_be, b_be;
   logic [31:0] a_wd, b_wd;
   logic [31:0] rdat [3][2];
   logic        rvld [3][2];

   logic [31:0] mm [256];
   rsp_t        rq0 [$];
   rsp_t        rq1 [$];
   int          head   [3][2];
   logic [31:0] last   [3][2];
   int          npulse [3][2];
   int          base   [3];
   int          cnt;
   int          ncmp, nerr;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      nios2_onchip_memory_dp #(.DATA_W(32), .ADDR_W(15), .READ_LATENCY(g + 1)) u_dut (
         .clk            (clk),
         .reset_n        (reset_n),
         .clken          (clken),
         .reset_req      (reset_req),
         .a_address      (a_addr),
         .a_chipselect   (a_cs),
         .a_read         (a_rd),
         .a_write        (a_wr),
         .a_byteenable   (a_be),
         .a_writedata    (a_wd),
         .a_readdata     (rdat[g][0]),
         .a_readdatavalid(rvld[g][0]),
         .b_address      (b_addr),
         .b_chipselect   (b_cs),
         .b_read         (b_rd),
         .b_write        (b_wr),
         .b_byteenable   (b_be),
         .b_writedata    (b_wd),
         .b_readdata     (rdat[g][1]),
         .b_readdatavalid(rvld[g][1])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] lanes);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   function automatic int qsize(input int p);
      return (p == 0) ? rq0.size() : rq1.size();
   endfunction

   function automatic rsp_t qget(input int p, input int i);
      if (p == 0) return rq0[i];
      return rq1[i];
   endfunction

   task automatic chk(input string name, input int d, input int p,
                      input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s lat%0d port_%s: observed %h expected %h",
                name, d + 1, (p == 0) ? "a" : "b", obs, exp);
      end
   endtask

   task automatic clear_model();
      rq0.delete();
      rq1.delete();
      for (int d = 0; d < 3; d++)
         for (int p = 0; p < 2; p++) begin
            head[d][p] = 0;
            last[d][p] = '0;
         end
   endtask

   // A read accepted on the en-edge numbered T is due while cnt == T + latency - 1 and en is high.
   task automatic check_outputs();
      logic en_now, ev;
      rsp_t e;
      en_now = clken & ~reset_req;
      for (int d = 0; d < 3; d++)
         for (int p = 0; p < 2; p++) begin
            ev = 1'b0;
            e  = '{0, 32'h0};
            if (en_now && head[d][p] < qsize(p)) begin
               e = qget(p, head[d][p]);
               if (e.tag + d == cnt) ev = 1'b1;
            end
            chk("readdatavalid", d, p, {31'b0, rvld[d][p]}, {31'b0, ev});
            if (ev) begin
               chk("readdata", d, p, rdat[d][p], e.data);
               last[d][p] = e.data;
               head[d][p]++;
            end else if (en_now) begin
               chk("readdata_hold", d, p, rdat[d][p], last[d][p]);
            end
            if (rvld[d][p] === 1'b1) npulse[d][p]++;
         end
   endtask

   task automatic model_edge();
      if (reset_n && clken && !reset_req) begin
         cnt++;
         if (b_cs && b_wr) mm[b_addr[7:0]] = merge(mm[b_addr[7:0]], b_wd, b_be);
         if (a_cs && a_wr) mm[a_addr[7:0]] = merge(mm[a_addr[7:0]], a_wd, a_be);
         if (a_cs && a_rd && !a_wr) rq0.push_back('{cnt, mm[a_addr[7:0]]});
         if (b_cs && b_rd && !b_wr) rq1.push_back('{cnt, mm[b_addr[7:0]]});
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      a_cs = 0; a_rd = 0; a_wr = 0; a_addr = '0; a_be = '0; a_wd = '0;
      b_cs = 0; b_rd = 0; b_wr = 0; b_addr = '0; b_be = '0; b_wd = '0;
   endtask

   task automatic opa(input logic rd, input logic wr, input logic [14:0] ad,
                      input logic [3:0] be, input logic [31:0] wd);
      a_cs = 1; a_rd = rd; a_wr = wr; a_addr = ad; a_be = be; a_wd = wd;
   endtask

   task automatic opb(input logic rd, input logic wr, input logic [14:0] ad,
                      input logic [3:0] be, input logic [31:0] wd);
      b_cs = 1; b_rd = rd; b_wr = wr; b_addr = ad; b_be = be; b_wd = wd;
   endtask

   task automatic mark_pulses();
      for (int d = 0; d < 3; d++) base[d] = npulse[d][0] + npulse[d][1];
   endtask

   task automatic check_pulses(input string name, input int want);
      for (int d = 0; d < 3; d++)
         chk(name, d, 0, npulse[d][0] + npulse[d][1] - base[d], want);
   endtask

   initial begin
      ncmp = 0; nerr = 0; cnt = 0;
      reset_n = 0; clken = 1; reset_req = 0;
      idle();
      clear_model();
      for (int d = 0; d < 3; d++) begin npulse[d][0] = 0; npulse[d][1] = 0; end
      #1;
      for (int d = 0; d < 3; d++)
         for (int p = 0; p < 2; p++) begin
            chk("reset_valid", d, p, {31'b0, rvld[d][p]}, 32'h0);
            chk("reset_data", d, p, rdat[d][p], 32'h0);
         end
      repeat (3) cycle();
      reset_n = 1;
      cycle();

      // Zero the low 256 words so later directed expectations start from known contents.
      for (int i = 0; i < 128; i++) begin
         opa(0, 1, 15'(2 * i), 4'hF, 32'h0);
         opb(0, 1, 15'(2 * i + 1), 4'hF, 32'h0);
         cycle();
      end
      idle();

      // Byte-lane write then read back on port a
      opa(0, 1, 15'h10, 4'hF, 32'hAABBCCDD); cycle();
      opa(0, 1, 15'h10, 4'h5, 32'h11223344); cycle();
      opa(1, 0, 15'h10, 4'h0, 32'h0);        cycle();
      idle(); repeat (4) cycle();
      for (int d = 0; d < 3; d++) chk("byte_lane", d, 0, rdat[d][0], 32'hAA22CC44);

      // Cross-port bypass: b reads while a writes low lanes of the same word
      opa(0, 1, 15'h20, 4'h3, 32'hFFFFFFFF);
      opb(1, 0, 15'h20, 4'h0, 32'h0);
      cycle();
      idle(); repeat (4) cycle();
      for (int d = 0; d < 3; d++) chk("bypass", d, 1, rdat[d][1], 32'h0000FFFF);

      // Write/write collision, a wins on overlapping lanes
      opa(0, 1, 15'h30, 4'hC, 32'h11111111);
      opb(0, 1, 15'h30, 4'h6, 32'h22222222);
      cycle();
      idle();
      opa(1, 0, 15'h30, 4'h0, 32'h0); cycle();
      idle(); repeat (4) cycle();
      for (int d = 0; d < 3; d++) chk("collision", d, 0, rdat[d][0], 32'h11112200);

      // Read+write on one port: write wins, no response; following read returns it
      mark_pulses();
      opa(1, 1, 15'h40, 4'hF, 32'h5A5A5A5A); cycle();
      opa(1, 0, 15'h40, 4'h0, 32'h0);        cycle();
      idle(); repeat (4) cycle();
      check_pulses("rw_pulses", 1);
      for (int d = 0; d < 3; d++) chk("rw_read", d, 0, rdat[d][0], 32'h5A5A5A5A);

      // Stall: 4 back-to-back reads with clken low for 3 cycles after the second accept
      for (int i = 0; i < 4; i++) begin
         opa(0, 1, 15'(8'h50 + i), 4'hF, 32'hC0DE0000 + i); cycle();
      end
      mark_pulses();
      opa(1, 0, 15'h50, 4'h0, 32'h0); cycle();
      opa(1, 0, 15'h51, 4'h0, 32'h0); cycle();
      opa(1, 0, 15'h52, 4'h0, 32'h0);
      clken = 0; repeat (3) cycle();
      clken = 1; cycle();
      opa(1, 0, 15'h53, 4'h0, 32'h0); cycle();
      idle(); repeat (6) cycle();
      check_pulses("stall_pulses", 4);
      for (int d = 0; d < 3; d++) chk("stall_last", d, 0, rdat[d][0], 32'hC0DE0003);

      // Reset with two reads in flight: outputs clear at once, nothing stale afterwards
      opa(1, 0, 15'h50, 4'h0, 32'h0); cycle();
      opa(1, 0, 15'h51, 4'h0, 32'h0); cycle();
      reset_n = 0;
      #1;
      for (int d = 0; d < 3; d++)
         for (int p = 0; p < 2; p++) begin
            chk("midrst_valid", d, p, {31'b0, rvld[d][p]}, 32'h0);
            chk("midrst_data", d, p, rdat[d][p], 32'h0);
         end
      clear_model();
      idle();
      mark_pulses();
      repeat (3) cycle();
      reset_n = 1;
      repeat (6) cycle();
      check_pulses("no_stale", 0);

      // Randomised traffic on a small address window so collisions are frequent
      for (int n = 0; n < 400; n++) begin
         clken     = ($urandom_range(0, 9) != 0);
         reset_req = ($urandom_range(0, 19) == 0);
         a_cs = ($urandom_range(0, 3) != 0); a_rd = 1'($urandom); a_wr = 1'($urandom);
         a_addr = 15'($urandom_range(0, 15)); a_be = 4'($urandom); a_wd = $urandom;
         b_cs = ($urandom_range(0, 3) != 0); b_rd = 1'($urandom); b_wr = 1'($urandom);
         b_addr = 15'($urandom_range(0, 15)); b_be = 4'($urandom); b_wd = $urandom;
         cycle();
      end
      idle();
      clken = 1; reset_req = 0;
      repeat (6) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
